smbm_param: RTL and testbench

Parametrised sorted multi-metric buffer manager. Holds up to DEPTH entries, each an id plus NUM_METRICS metric values. It keeps one list sorted by id and one list per metric sorted by that metric's value; every metric-list slot stores the owning id rather than a positional pointer, so shifts never leave references stale. Compared with the fixed 64x8 manager it adds:
- valid/ready request handshake,
- occupancy count and error status,
- an atomic UPDATE operation,
- masked and unmasked sorted reads.

It sits between the scheduler front end and the ranking/select logic.

---
 rtl/smbm_param.sv | 167 ++++++++++++++++
 tb/tb_smbm_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/smbm_param.sv
// smbm_param: sorted multi-metric buffer manager; an id list plus one id-keyed list per metric
module smbm_param #(
  parameter int DEPTH       = 64,
  parameter int DEPTH_LOG   = 6,
  parameter int NUM_METRICS = 8,
  parameter int METRIC_LOG  = 3,
  parameter int METRIC_W    = 8,
  parameter int ID_W        = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      opcode,
  input  logic [ID_W-1:0]                 id,
  input  logic [NUM_METRICS*METRIC_W-1:0] metric_val,
  input  logic [2**ID_W-1:0]              in_mask,
  input  logic [METRIC_LOG-1:0]           metricX,
  output logic                            resp_valid,
  output logic [2:0]                      status,
  output logic [DEPTH_LOG:0]              count,
  output logic [DEPTH-1:0]                out_vld,
  output logic [DEPTH*METRIC_W-1:0]       out_val,
  output logic [DEPTH*ID_W-1:0]           out_id
);
  typedef logic [DEPTH_LOG:0] cnt_t;
  typedef enum logic [2:0] {IDLE, LOOKUP, DEL_COMMIT, ADD_LOOKUP, ADD_COMMIT, READ, RESP} state_t;
  localparam logic [2:0] OP_ADD = 3'd0, OP_DEL = 3'd1, OP_RDM = 3'd2, OP_RDA = 3'd3, OP_UPD = 3'd4;
  localparam logic [2:0] ST_OK = 3'd0, ST_FULL = 3'd1, ST_MISS = 3'd2, ST_DUP = 3'd3, ST_BAD = 3'd4;
  state_t state, state_nxt;
  logic [2:0] op;
  logic [ID_W-1:0] rid;
  logic [NUM_METRICS*METRIC_W-1:0] rval;
  logic [2**ID_W-1:0] rmask;
  logic [METRIC_LOG-1:0] rmx;
  logic [ID_W-1:0] id_list [DEPTH];
  logic [ID_W-1:0] met_id [NUM_METRICS][DEPTH];
  logic [METRIC_W-1:0] met_key [NUM_METRICS][DEPTH];
  cnt_t wc, f_id, p_id, pos_id;
  cnt_t f_m [NUM_METRICS];
  cnt_t p_m [NUM_METRICS];
  cnt_t pos_m [NUM_METRICS];
  logic acc, fnd, full, bad;
  logic [DEPTH-1:0] rd_vld;
  logic [DEPTH*METRIC_W-1:0] rd_val;
  logic [DEPTH*ID_W-1:0] rd_id;
  assign acc = req_valid && req_ready;
  // an UPDATE never reports FULL: its own entry was just removed
  assign full = count == cnt_t'(DEPTH) && op != OP_UPD;
  assign bad = !(op == OP_RDM || op == OP_RDA) || {1'b0, rmx} >= (METRIC_LOG+1)'(NUM_METRICS);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (acc) state_nxt = opcode == OP_ADD ? ADD_LOOKUP : (opcode == OP_DEL || opcode == OP_UPD) ? LOOKUP : READ;
      LOOKUP:     state_nxt = fnd ? DEL_COMMIT : RESP;
      DEL_COMMIT: state_nxt = op == OP_UPD ? ADD_LOOKUP : RESP;
      ADD_LOOKUP: state_nxt = (full || fnd) ? RESP : ADD_COMMIT;
      ADD_COMMIT: state_nxt = RESP;
      READ:       state_nxt = RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE && !rst;
    resp_valid = state == RESP;
  end
  // during an UPDATE the count register stays put, so the re-insert sees one fewer valid slot
  always_comb begin
    wc = count - cnt_t'(op == OP_UPD && state == ADD_LOOKUP);
    fnd = 1'b0;
    f_id = '0;
    p_id = wc;
    for (int m = 0; m < NUM_METRICS; m++) begin
      f_m[m] = '0;
      p_m[m] = wc;
    end
    for (int i = DEPTH-1; i >= 0; i--) if (cnt_t'(i) < wc) begin
      if (id_list[i] == rid) begin
        fnd = 1'b1;
        f_id = cnt_t'(i);
      end
      if (id_list[i] > rid) p_id = cnt_t'(i);
      for (int m = 0; m < NUM_METRICS; m++) begin
        if (met_id[m][i] == rid) f_m[m] = cnt_t'(i);
        if (met_key[m][i] > rval[m*METRIC_W +: METRIC_W]) p_m[m] = cnt_t'(i);
      end
    end
  end
  always_comb begin
    rd_vld = '0;
    rd_val = '1;
    rd_id = '1;
    for (int i = 0; i < DEPTH; i++) if (cnt_t'(i) < count && (op == OP_RDA || rmask[met_id[rmx][i]])) begin
      rd_vld[i] = 1'b1;
      rd_val[i*METRIC_W +: METRIC_W] = met_key[rmx][i];
      rd_id[i*ID_W +: ID_W] = met_id[rmx][i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= ST_OK;
      count <= '0;
      out_vld <= '0;
      out_val <= '1;
      out_id <= '1;
    end else begin
      case (state)
        IDLE: if (acc) begin
          op <= opcode;
          rid <= id;
          rval <= metric_val;
          rmask <= in_mask;
          rmx <= metricX;
        end
        LOOKUP: begin
          pos_id <= f_id;
          pos_m <= f_m;
          if (!fnd) status <= ST_MISS;
        end
        DEL_COMMIT: begin
          for (int i = 0; i < DEPTH; i++) if (cnt_t'(i) >= pos_id) id_list[i] <= id_list[(i+1)%DEPTH];
          for (int m = 0; m < NUM_METRICS; m++)
            for (int i = 0; i < DEPTH; i++) if (cnt_t'(i) >= pos_m[m]) begin
              met_id[m][i] <= met_id[m][(i+1)%DEPTH];
              met_key[m][i] <= met_key[m][(i+1)%DEPTH];
            end
          if (op != OP_UPD) begin
            count <= count - cnt_t'(1);
            status <= ST_OK;
          end
        end
        ADD_LOOKUP: begin
          pos_id <= p_id;
          pos_m <= p_m;
          status <= full ? ST_FULL : fnd ? ST_DUP : status;
        end
        ADD_COMMIT: begin
          for (int i = 0; i < DEPTH; i++)
            if (cnt_t'(i) > pos_id) id_list[i] <= id_list[(i+DEPTH-1)%DEPTH];
            else if (cnt_t'(i) == pos_id) id_list[i] <= rid;
          for (int m = 0; m < NUM_METRICS; m++)
            for (int i = 0; i < DEPTH; i++)
              if (cnt_t'(i) > pos_m[m]) begin
                met_id[m][i] <= met_id[m][(i+DEPTH-1)%DEPTH];
                met_key[m][i] <= met_key[m][(i+DEPTH-1)%DEPTH];
              end else if (cnt_t'(i) == pos_m[m]) begin
                met_id[m][i] <= rid;
                met_key[m][i] <= rval[m*METRIC_W +: METRIC_W];
              end
          if (op != OP_UPD) count <= count + cnt_t'(1);
          status <= ST_OK;
        end
        READ: begin
          status <= bad ? ST_BAD : ST_OK;
          if (!bad) begin
            out_vld <= rd_vld;
            out_val <= rd_val;
            out_id <= rd_id;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_smbm_param.sv
// tb_smbm_param: directed bench for smbm_param against a set-of-entries reference model
module tb_smbm_param;
  localparam int D = 64, NM = 8, MW = 8, IW = 6;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ready, resp_valid;
  logic [2:0] opcode = '0, status;
  logic [IW-1:0] id = '0;
  logic [NM*MW-1:0] metric_val = '0;
  logic [2**IW-1:0] in_mask = '0;
  logic [2:0] metricX = '0;
  logic [6:0] count;
  logic [D-1:0] out_vld;
  logic [D*MW-1:0] out_val;
  logic [D*IW-1:0] out_id;
  smbm_param dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .opcode(opcode),
    .id(id), .metric_val(metric_val), .in_mask(in_mask), .metricX(metricX), .resp_valid(resp_valid),
    .status(status), .count(count), .out_vld(out_vld), .out_val(out_val), .out_id(out_id));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  // reference model: a set of present ids with their metrics and an insertion sequence number
  bit pres [64];
  logic [7:0] mv [64][8];
  int seq [64];
  int seq_n = 0;
  logic [2:0] p_st, h_st = '0;
  logic [6:0] p_cnt, h_cnt = '0;
  bit p_rd;
  logic [D-1:0] p_vld, h_vld = '0;
  logic [D*MW-1:0] p_val, h_val = '1;
  logic [D*IW-1:0] p_id, h_id = '1;
  int exp_resp = -1, acc = -100, lat_c = 0;
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  function automatic int mcount();
    int n = 0;
    for (int j = 0; j < 64; j++) n += pres[j] ? 1 : 0;
    return n;
  endfunction
  task automatic model_clear();
    for (int j = 0; j < 64; j++) pres[j] = 0;
    h_st = '0; h_cnt = '0; h_vld = '0; h_val = '1; h_id = '1;
  endtask
  task automatic model(input logic [2:0] o, input int i, input logic [63:0] v, input logic [63:0] mk,
                       input int mx, output int lat);
    int n, best;
    bit used [64];
    n = mcount();
    p_rd = 0; p_cnt = 7'(n); lat = 2;
    if (o == 3'd0) begin
      if (n == 64) p_st = 3'd1;
      else if (pres[i]) p_st = 3'd3;
      else begin
        pres[i] = 1; seq[i] = seq_n++;
        for (int m = 0; m < 8; m++) mv[i][m] = v[m*8 +: 8];
        p_st = 3'd0; lat = 3; p_cnt = 7'(n + 1);
      end
    end else if (o == 3'd1 || o == 3'd4) begin
      if (!pres[i]) p_st = 3'd2;
      else if (o == 3'd1) begin
        pres[i] = 0; p_st = 3'd0; lat = 3; p_cnt = 7'(n - 1);
      end else begin
        seq[i] = seq_n++;
        for (int m = 0; m < 8; m++) mv[i][m] = v[m*8 +: 8];
        p_st = 3'd0; lat = 5;
      end
    end else if (o == 3'd2 || o == 3'd3) begin
      p_st = 3'd0; p_rd = 1; p_vld = '0; p_val = '1; p_id = '1;
      for (int j = 0; j < 64; j++) used[j] = 0;
      for (int k = 0; k < n; k++) begin
        best = -1;
        for (int j = 0; j < 64; j++)
          if (pres[j] && !used[j] && (best < 0 || mv[j][mx] < mv[best][mx] ||
              (mv[j][mx] == mv[best][mx] && seq[j] < seq[best]))) best = j;
        used[best] = 1;
        if (o == 3'd3 || mk[best]) begin
          p_vld[k] = 1'b1;
          p_val[k*8 +: 8] = mv[best][mx];
          p_id[k*6 +: 6] = 6'(best);
        end
      end
    end else p_st = 3'd4;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      h_st = '0; h_cnt = '0; h_vld = '0; h_val = '1; h_id = '1;
    end else if (cyc == exp_resp) begin
      h_st = p_st; h_cnt = p_cnt;
      if (p_rd) begin h_vld = p_vld; h_val = p_val; h_id = p_id; end
    end
    chk("resp_valid", 512'(resp_valid), 512'(!rst && cyc == exp_resp));
    chk("req_ready", 512'(req_ready), 512'(!rst && !(cyc >= acc && cyc < acc + lat_c)));
    if (!rst) begin
      chk("status", 512'(status), 512'(h_st));
      chk("count", 512'(count), 512'(h_cnt));
      chk("out_vld", 512'(out_vld), 512'(h_vld));
      chk("out_val", out_val, h_val);
      chk("out_id", 512'(out_id), 512'(h_id));
    end
  end
  task automatic req(input logic [2:0] o, input int i, input logic [63:0] v, input logic [63:0] mk, input int mx);
    int w = 0, lat;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      errors++;
      $display("FAIL ready_timeout act=0 exp=1");
    end
    opcode = o; id = 6'(i); metric_val = v; in_mask = mk; metricX = 3'(mx); req_valid = 1'b1;
    model(o, i, v, mk, mx, lat);
    acc = cyc + 1; lat_c = lat; exp_resp = acc + lat - 1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (lat) @(negedge clk);
  endtask
  function automatic logic [63:0] fv(input int i);
    logic [63:0] r;
    for (int m = 0; m < 8; m++) r[m*8 +: 8] = 8'(((i * 7 + m * 13) % 16) * 3);
    return r;
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_count", 512'(count), 512'(0));
    chk("reset_vld", 512'(out_vld), 512'(0));
    req(3'd0, 5, {8{8'd20}}, '0, 0);
    chk("add5_count", 512'(count), 512'(1));
    req(3'd3, 0, '0, '0, 0);
    chk("rd1_id", 512'(out_id[5:0]), 512'(5));
    chk("rd1_val", 512'(out_val[7:0]), 512'(20));
    chk("rd1_vld", 512'(out_vld), 512'(64'h1));
    req(3'd0, 3, {8{8'd30}}, '0, 0);
    req(3'd0, 7, {8{8'd10}}, '0, 0);
    req(3'd0, 1, {8{8'd20}}, '0, 0);
    req(3'd3, 0, '0, '0, 0);
    chk("rd2_ids", 512'(out_id[23:0]), 512'({6'd3, 6'd1, 6'd5, 6'd7}));
    chk("rd2_vals", 512'(out_val[31:0]), 512'({8'd30, 8'd20, 8'd20, 8'd10}));
    req(3'd1, 3, '0, '0, 0);
    chk("del3_count", 512'(count), 512'(3));
    req(3'd3, 0, '0, '0, 0);
    chk("rd3_ids", 512'(out_id[17:0]), 512'({6'd1, 6'd5, 6'd7}));
    req(3'd1, 3, '0, '0, 0);
    chk("del3_miss", 512'(status), 512'(2));
    req(3'd4, 7, {8{8'd99}}, '0, 0);
    req(3'd3, 0, '0, '0, 0);
    chk("upd7_ids", 512'(out_id[17:0]), 512'({6'd7, 6'd1, 6'd5}));
    chk("upd7_count", 512'(count), 512'(3));
    req(3'd0, 5, '0, '0, 0);
    chk("dup", 512'(status), 512'(3));
    req(3'd7, 0, '0, '0, 0);
    chk("badop", 512'(status), 512'(4));
    req(3'd5, 0, '0, '0, 0);
    req(3'd2, 0, '0, 64'h20, 0);
    chk("mask_vld", 512'(out_vld), 512'(64'h1));
    chk("mask_slot1", 512'(out_val[15:8]), 512'(8'hff));
    for (int i = 0; i < 64; i++) req(3'd0, i, fv(i), '0, 0);
    chk("fill_count", 512'(count), 512'(64));
    req(3'd0, 9, '0, '0, 0);
    chk("full", 512'(status), 512'(1));
    req(3'd4, 11, {8{8'd7}}, '0, 0);
    for (int m = 0; m < 8; m++) req(3'd3, 0, '0, '0, m);
    req(3'd2, 0, '0, 64'hA5A5_0F0F_3C3C_9999, 3);
    req(3'd1, 10, '0, '0, 0);
    req(3'd1, 20, '0, '0, 0);
    req(3'd4, 30, fv(3), '0, 0);
    req(3'd4, 40, {8{8'd0}}, '0, 0);
    req(3'd3, 0, '0, '0, 2);
    req(3'd2, 0, '0, 64'hFFFF_0000_FFFF_0001, 6);
    req(3'd6, 0, '0, '0, 0);
    opcode = 3'd0; id = 6'd20; metric_val = '0; req_valid = 1'b1;
    acc = cyc + 1; lat_c = 3; exp_resp = acc + 2;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1; exp_resp = -1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0; acc = -100;
    repeat (4) @(negedge clk);
    chk("midrst_count", 512'(count), 512'(0));
    req(3'd0, 2, fv(2), '0, 0);
    req(3'd3, 0, '0, '0, 4);
    chk("post_rst_vld", 512'(out_vld), 512'(64'h1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
